fma_exp_retire: RTL

Retire stage directly downstream of the FMA exponent generator. Captures each operation's result exponent and exponent-exception indications, and turns them into per-operation IEEE flags (NV, OF, UF). Presents the result through a valid/ready handshake and maintains sticky accumulated flags and a retired-operation counter for the FPU control logic.

---
 rtl/fma_exp_retire_if.sv | 34 +++
 rtl/fma_exp_retire.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fma_exp_retire_if.sv
// Result handshake bundle between the FMA exponent generator, the retire stage and
// its consumer. The slave modport is the retire stage; master is the surrounding logic.
interface fma_exp_retire_if #(
  parameter int TAGW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [10:0]     in_w;
  logic            in_prodof;
  logic            in_sumof;
  logic            in_sumuf;
  logic            in_invalid;
  logic [TAGW-1:0] in_tag;

  logic            out_valid;
  logic            out_ready;
  logic [10:0]     out_w;
  logic [2:0]      out_flags;
  logic [TAGW-1:0] out_tag;

  modport slave (
    input  in_valid, in_w, in_prodof, in_sumof, in_sumuf, in_invalid, in_tag,
    output in_ready,
    output out_valid, out_w, out_flags, out_tag,
    input  out_ready
  );

  modport master (
    output in_valid, in_w, in_prodof, in_sumof, in_sumuf, in_invalid, in_tag,
    input  in_ready,
    input  out_valid, out_w, out_flags, out_tag,
    output out_ready
  );
endinterface

// File: rtl/fma_exp_retire.sv
// FMA exponent retire stage: derives {NV,OF,UF} per op, queues results in order,
// keeps sticky flags and a retire counter. Define FMA_EXP_RETIRE_SKID_EN for a 2-entry skid buffer.
module fma_exp_retire #(
  parameter int TAGW = 4,
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                resetn,
  fma_exp_retire_if.slave     bus,
  input  logic                flag_clr,
  output logic [2:0]          fflags,
  output logic [CNTW-1:0]     retire_cnt
);

  typedef struct packed {
    logic [10:0]     w;
    logic [2:0]      flags;
    logic [TAGW-1:0] tag;
  } entry_t;

`ifdef FMA_EXP_RETIRE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  entry_t           mem_reg [DEPTH];
  entry_t           head;
  entry_t           in_entry;
  logic [DEPTH-1:0] wr_en;
  logic             accept;
  logic             retire;
  logic             of_bit;
  logic             wr_sel;

  assign accept = bus.in_valid & bus.in_ready;
  assign retire = bus.out_valid & bus.out_ready;

  // Invalid masks overflow, and any overflow masks underflow.
  always_comb begin
    of_bit         = (bus.in_prodof | bus.in_sumof) & ~bus.in_invalid;
    in_entry.w     = bus.in_w;
    in_entry.tag   = bus.in_tag;
    in_entry.flags = {bus.in_invalid, of_bit, bus.in_sumuf & ~bus.in_invalid & ~of_bit};
  end

  always_comb begin
    count_next = count_reg;
    if (accept && !retire) begin
      count_next = count_reg + 2'd1;
    end else if (!accept && retire) begin
      count_next = count_reg - 2'd1;
    end
  end

`ifdef FMA_EXP_RETIRE_SKID_EN
  logic wr_ptr_reg;
  logic rd_ptr_reg;
  logic in_ready_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      in_ready_reg <= 1'b1;
    end else begin
      wr_ptr_reg   <= wr_ptr_reg ^ accept;
      rd_ptr_reg   <= rd_ptr_reg ^ retire;
      in_ready_reg <= (count_next < 2'd2);
    end
  end

  assign wr_sel       = wr_ptr_reg;
  assign bus.in_ready = resetn & in_ready_reg;

  always_comb begin
    head = mem_reg[rd_ptr_reg];
  end
`else
  assign wr_sel       = 1'b0;
  // A full entry may be refilled in the same cycle it retires.
  assign bus.in_ready = resetn & (~bus.out_valid | bus.out_ready);

  always_comb begin
    head = mem_reg[0];
  end
`endif

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = accept & (wr_sel == 1'(gi));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          mem_reg[i] <= in_entry;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg <= 2'd0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign bus.out_valid = (count_reg != 2'd0);
  assign bus.out_w     = head.w;
  assign bus.out_flags = head.flags;
  assign bus.out_tag   = head.tag;

  // A clear coincident with a retire keeps only the retiring op's flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fflags     <= 3'b000;
      retire_cnt <= '0;
    end else begin
      if (flag_clr && retire) begin
        fflags <= head.flags;
      end else if (flag_clr) begin
        fflags <= 3'b000;
      end else if (retire) begin
        fflags <= fflags | head.flags;
      end
      if (retire) begin
        retire_cnt <= retire_cnt + 1'b1;
      end
    end
  end

endmodule
